trans_layer_sched: RTL and testbench

- Pop scheduler and configuration controller for the transaction layer's four virtual-channel output FIFOs (data_out0..3).
- Sequences init and threshold loading, then arbitrates round-robin among the non-empty FIFOs whose downstream destination can accept data.
- Drives pop0..pop3 and the latched almost-full/almost-empty thresholds of the transaction layer.
- Sits between the trans_layer datapath and its downstream consumers.

---
 rtl/trans_layer_pkg.sv | 35 +++
 rtl/rr_arbiter4.sv | 38 +++
 rtl/trans_layer_sched.sv | 145 ++++++++++++++
 tb/tb_trans_layer_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/trans_layer_pkg.sv
// ---------------------------------------------------------------------------
// trans_layer_pkg
// Shared definitions for the transaction-layer pop scheduler:
//   - state_t         : scheduler FSM encoding (RESET/INIT/IDLE/ACTIVE)
//   - NUM_VC          : number of virtual-channel FIFOs
//   - DEF_TH_AF/AE    : threshold values applied on reset
//   - onehot_to_idx   : converts a 4-bit one-hot grant into its index
// ---------------------------------------------------------------------------
package trans_layer_pkg;

    localparam int NUM_VC = 4;

    localparam logic [2:0] DEF_TH_AF = 3'd6;
    localparam logic [2:0] DEF_TH_AE = 3'd1;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_VC-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Purely combinational 4-way round-robin select. The search starts one
// position after last_idx and wraps, so the previous winner has the lowest
// priority.
// Ports:
//   req      in  4  request vector, bit i = requester i
//   last_idx in  2  index of the previous grant
//   grant    out 4  one-hot grant (all zero when no request)
//   valid    out 1  at least one request was granted
// ---------------------------------------------------------------------------
module rr_arbiter4
    import trans_layer_pkg::*;
(
    input  logic [NUM_VC-1:0] req,
    input  logic [1:0]        last_idx,
    output logic [NUM_VC-1:0] grant,
    output logic              valid
);

    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant = '0;
        found = 1'b0;
        idx   = 2'd0;
        // Offsets 1..4: offset 4 revisits last_idx itself as the final choice.
        for (int off = 1; off <= NUM_VC; off++) begin
            idx = last_idx + 2'(off);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/trans_layer_sched.sv
// ---------------------------------------------------------------------------
// trans_layer_sched
// Pop scheduler and threshold controller for the four VC output FIFOs of the
// transaction layer. Sequences reset -> init (threshold load) -> idle, then
// pops one eligible FIFO per cycle in round-robin order.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   init                       enter/hold INIT and load thresholds
//   th_almost_full_in/_empty_in threshold values loaded while in INIT
//   fifo_empty[3:0]            per-FIFO empty flags
//   dest_almost_full[3:0]      per-destination backpressure
//   pop0..pop3                 registered one-cycle pop strobes
//   th_almost_full/_empty      latched thresholds
//   state                      FSM state (0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE)
//   grant_idx                  index of the most recent grant
//   idle                       IDLE state with all FIFOs empty
//   pop_cnt                    wrapping count of pops issued
// ---------------------------------------------------------------------------
module trans_layer_sched
    import trans_layer_pkg::*;
#(
    parameter int                         MAIN_QUEUE_SIZE = 3,
    parameter logic [MAIN_QUEUE_SIZE-1:0] TH_AF_DEFAULT   = MAIN_QUEUE_SIZE'(DEF_TH_AF),
    parameter logic [MAIN_QUEUE_SIZE-1:0] TH_AE_DEFAULT   = MAIN_QUEUE_SIZE'(DEF_TH_AE),
    parameter int                         CNT_SIZE        = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [MAIN_QUEUE_SIZE-1:0] th_almost_full_in,
    input  logic [MAIN_QUEUE_SIZE-1:0] th_almost_empty_in,
    input  logic [NUM_VC-1:0]          fifo_empty,
    input  logic [NUM_VC-1:0]          dest_almost_full,
    output logic                       pop0,
    output logic                       pop1,
    output logic                       pop2,
    output logic                       pop3,
    output logic [MAIN_QUEUE_SIZE-1:0] th_almost_full,
    output logic [MAIN_QUEUE_SIZE-1:0] th_almost_empty,
    output logic [1:0]                 state,
    output logic [1:0]                 grant_idx,
    output logic                       idle,
    output logic [CNT_SIZE-1:0]        pop_cnt
);

    state_t                     state_reg, state_next;
    logic [NUM_VC-1:0]          pop_reg, pop_next;
    logic [1:0]                 grant_idx_reg, grant_idx_next;
    logic [CNT_SIZE-1:0]        pop_cnt_reg, pop_cnt_next;
    logic [MAIN_QUEUE_SIZE-1:0] th_af_reg, th_af_next;
    logic [MAIN_QUEUE_SIZE-1:0] th_ae_reg, th_ae_next;

    logic [NUM_VC-1:0] candidate;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] arb_grant;
    logic              arb_valid;

    // A FIFO popped last cycle still shows a stale empty flag, so it is
    // masked for one cycle to avoid underflow.
    assign candidate = ~fifo_empty & ~dest_almost_full;
    assign eligible  = candidate & ~pop_reg;

    rr_arbiter4 u_arb (
        .req      (eligible),
        .last_idx (grant_idx_reg),
        .grant    (arb_grant),
        .valid    (arb_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_RESET;
            pop_reg       <= '0;
            grant_idx_reg <= 2'd3;
            pop_cnt_reg   <= '0;
            th_af_reg     <= TH_AF_DEFAULT;
            th_ae_reg     <= TH_AE_DEFAULT;
        end else begin
            state_reg     <= state_next;
            pop_reg       <= pop_next;
            grant_idx_reg <= grant_idx_next;
            pop_cnt_reg   <= pop_cnt_next;
            th_af_reg     <= th_af_next;
            th_ae_reg     <= th_ae_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pop_next       = '0;
        grant_idx_next = grant_idx_reg;
        pop_cnt_next   = pop_cnt_reg;
        th_af_next     = th_af_reg;
        th_ae_next     = th_ae_reg;
        unique case (state_reg)
            ST_RESET: begin
                state_next = ST_INIT;
            end
            ST_INIT: begin
                th_af_next   = th_almost_full_in;
                th_ae_next   = th_almost_empty_in;
                pop_cnt_next = '0;
                state_next   = init ? ST_INIT : ST_IDLE;
            end
            ST_IDLE: begin
                if (init) begin
                    // Counter reads zero for the whole INIT residency.
                    pop_cnt_next = '0;
                    state_next   = ST_INIT;
                end else if (|eligible) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    pop_cnt_next = '0;
                    state_next   = ST_INIT;
                end else if (arb_valid) begin
                    pop_next       = arb_grant;
                    grant_idx_next = onehot_to_idx(arb_grant);
                    pop_cnt_next   = pop_cnt_reg + CNT_SIZE'(1);
                end else if (!(|candidate)) begin
                    state_next = ST_IDLE;
                end
                // Otherwise the only work left is masked by the previous pop;
                // stay ACTIVE so a lone source is popped every other cycle.
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    assign pop0            = pop_reg[0];
    assign pop1            = pop_reg[1];
    assign pop2            = pop_reg[2];
    assign pop3            = pop_reg[3];
    assign th_almost_full  = th_af_reg;
    assign th_almost_empty = th_ae_reg;
    assign state           = state_reg;
    assign grant_idx       = grant_idx_reg;
    assign pop_cnt         = pop_cnt_reg;
    assign idle            = (state_reg == ST_IDLE) && (&fifo_empty);

endmodule

// File: tb/tb_trans_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_trans_layer_sched
// Directed bench for trans_layer_sched. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_trans_layer_sched;

    logic       clk;
    logic       reset;
    logic       init;
    logic [2:0] th_almost_full_in;
    logic [2:0] th_almost_empty_in;
    logic [3:0] fifo_empty;
    logic [3:0] dest_almost_full;
    logic       pop0, pop1, pop2, pop3;
    logic [2:0] th_almost_full;
    logic [2:0] th_almost_empty;
    logic [1:0] state;
    logic [1:0] grant_idx;
    logic       idle;
    logic [7:0] pop_cnt;

    logic [3:0] pops;
    assign pops = {pop3, pop2, pop1, pop0};

    int tests_run    = 0;
    int tests_failed = 0;

    trans_layer_sched dut (
        .clk                (clk),
        .reset              (reset),
        .init               (init),
        .th_almost_full_in  (th_almost_full_in),
        .th_almost_empty_in (th_almost_empty_in),
        .fifo_empty         (fifo_empty),
        .dest_almost_full   (dest_almost_full),
        .pop0               (pop0),
        .pop1               (pop1),
        .pop2               (pop2),
        .pop3               (pop3),
        .th_almost_full     (th_almost_full),
        .th_almost_empty    (th_almost_empty),
        .state              (state),
        .grant_idx          (grant_idx),
        .idle               (idle),
        .pop_cnt            (pop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t state=%0d pops=%b grant=%0d cnt=%0d", $time, state, pops, grant_idx, pop_cnt);
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0;
        th_almost_full_in = 3'd0; th_almost_empty_in = 3'd0;
        fifo_empty = 4'hF; dest_almost_full = 4'h0;
        #3;
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", state); end
        tests_run++; if (pops !== 4'b0000) begin tests_failed++; $display("FAIL reset_pops got %b exp 0000", pops); end
        tests_run++; if (th_almost_full !== 3'd6 || th_almost_empty !== 3'd1) begin tests_failed++; $display("FAIL reset_th got %0d/%0d exp 6/1", th_almost_full, th_almost_empty); end
        tests_run++; if (pop_cnt !== 8'd0 || grant_idx !== 2'd3 || idle !== 1'b0) begin tests_failed++; $display("FAIL reset_misc got cnt=%0d grant=%0d idle=%b exp 0/3/0", pop_cnt, grant_idx, idle); end
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        tests_run++; if (state !== 2'd1) begin tests_failed++; $display("FAIL reset_to_init got %0d exp 1", state); end
    endtask

    task automatic test_init();
        init = 1'b1; th_almost_full_in = 3'd5; th_almost_empty_in = 3'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (state !== 2'd1) begin tests_failed++; $display("FAIL init_hold cyc %0d got %0d exp 1", i, state); end
        end
        init = 1'b0;
        step();
        tests_run++; if (state !== 2'd2) begin tests_failed++; $display("FAIL init_exit got %0d exp 2", state); end
        tests_run++; if (th_almost_full !== 3'd5 || th_almost_empty !== 3'd2) begin tests_failed++; $display("FAIL init_th got %0d/%0d exp 5/2", th_almost_full, th_almost_empty); end
        tests_run++; if (idle !== 1'b1) begin tests_failed++; $display("FAIL init_idle got %b exp 1", idle); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_pop;
        fifo_empty = 4'h0;
        step();
        tests_run++; if (state !== 2'd3 || pops !== 4'b0000) begin tests_failed++; $display("FAIL rr_enter got state=%0d pops=%b exp 3/0000", state, pops); end
        for (int k = 0; k < 8; k++) begin
            step();
            exp_pop = 4'b0001 << (k % 4);
            tests_run++; if (pops !== exp_pop || pop_cnt !== 8'(k + 1)) begin tests_failed++; $display("FAIL rr_pop %0d got pops=%b cnt=%0d exp %b/%0d", k, pops, pop_cnt, exp_pop, k + 1); end
        end
        fifo_empty = 4'hF;
        step();
        tests_run++; if (state !== 2'd2 || pops !== 4'b0000 || idle !== 1'b1) begin tests_failed++; $display("FAIL rr_drain got state=%0d pops=%b idle=%b exp 2/0000/1", state, pops, idle); end
    endtask

    task automatic test_single_source();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
        fifo_empty = 4'b1011;
        step();
        tests_run++; if (state !== 2'd3 || pops !== 4'b0000) begin tests_failed++; $display("FAIL single_enter got state=%0d pops=%b exp 3/0000", state, pops); end
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++; if (pops !== exp_seq[k]) begin tests_failed++; $display("FAIL single_pop %0d got %b exp %b", k, pops, exp_seq[k]); end
        end
        tests_run++; if (grant_idx !== 2'd2 || pop_cnt !== 8'd10) begin tests_failed++; $display("FAIL single_grant got grant=%0d cnt=%0d exp 2/10", grant_idx, pop_cnt); end
        fifo_empty = 4'hF;
        step();
        tests_run++; if (state !== 2'd2) begin tests_failed++; $display("FAIL single_drain got %0d exp 2", state); end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        fifo_empty = 4'h0; dest_almost_full = 4'b0101;
        step();
        tests_run++; if (state !== 2'd3 || pops !== 4'b0000) begin tests_failed++; $display("FAIL bp_enter got state=%0d pops=%b exp 3/0000", state, pops); end
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++; if (pops !== exp_seq[k]) begin tests_failed++; $display("FAIL bp_pop %0d got %b exp %b", k, pops, exp_seq[k]); end
        end
        tests_run++; if (pop_cnt !== 8'd14 || grant_idx !== 2'd1) begin tests_failed++; $display("FAIL bp_cnt got cnt=%0d grant=%0d exp 14/1", pop_cnt, grant_idx); end
    endtask

    task automatic test_abort();
        init = 1'b1; th_almost_full_in = 3'd4; th_almost_empty_in = 3'd3;
        step();
        tests_run++; if (state !== 2'd1 || pops !== 4'b0000 || pop_cnt !== 8'd0) begin tests_failed++; $display("FAIL abort_enter got state=%0d pops=%b cnt=%0d exp 1/0000/0", state, pops, pop_cnt); end
        step();
        tests_run++; if (th_almost_full !== 3'd4 || th_almost_empty !== 3'd3 || pop_cnt !== 8'd0) begin tests_failed++; $display("FAIL abort_init got th=%0d/%0d cnt=%0d exp 4/3/0", th_almost_full, th_almost_empty, pop_cnt); end
        tests_run++; if (grant_idx !== 2'd1 || pops !== 4'b0000) begin tests_failed++; $display("FAIL abort_hold got grant=%0d pops=%b exp 1/0000", grant_idx, pops); end
    endtask

    task automatic test_wrap();
        int bad_onehot;
        bad_onehot = 0;
        init = 1'b0; dest_almost_full = 4'h0; fifo_empty = 4'h0;
        step();
        step();
        tests_run++; if (state !== 2'd3 || pop_cnt !== 8'd0) begin tests_failed++; $display("FAIL wrap_start got state=%0d cnt=%0d exp 3/0", state, pop_cnt); end
        for (int k = 0; k < 255; k++) begin
            step();
            if ($countones(pops) != 1) bad_onehot++;
        end
        tests_run++; if (bad_onehot !== 0) begin tests_failed++; $display("FAIL wrap_onehot got %0d bad cycles exp 0", bad_onehot); end
        tests_run++; if (pop_cnt !== 8'd255) begin tests_failed++; $display("FAIL wrap_255 got %0d exp 255", pop_cnt); end
        step();
        tests_run++; if (pop_cnt !== 8'd0) begin tests_failed++; $display("FAIL wrap_zero got %0d exp 0", pop_cnt); end
    endtask

    task automatic test_reset_mid();
        step();
        tests_run++; if (pops === 4'b0000) begin tests_failed++; $display("FAIL mid_pre got pops=%b exp nonzero", pops); end
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (pops !== 4'b0000 || state !== 2'd0 || pop_cnt !== 8'd0) begin tests_failed++; $display("FAIL mid_reset got pops=%b state=%0d cnt=%0d exp 0000/0/0", pops, state, pop_cnt); end
        tests_run++; if (th_almost_full !== 3'd6 || th_almost_empty !== 3'd1 || grant_idx !== 2'd3) begin tests_failed++; $display("FAIL mid_reset_th got %0d/%0d grant=%0d exp 6/1/3", th_almost_full, th_almost_empty, grant_idx); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_round_robin();
        test_single_source();
        test_backpressure();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
